// File: rtl/shape_bbox_tracker.sv
// rtl/shape_bbox_tracker.sv - per-frame bounding box, area and coordinate sums of dark pixels
module shape_bbox_tracker #(
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  parameter int MIN_AREA = 16
) (
  input  logic        VGA_CLK,
  input  logic        reset_n,
  input  logic        iVGA_HS,
  input  logic        iVGA_VS,
  input  logic        iVGA_BLANK_N,
  input  logic        pix_dark,
  input  logic        freeze,
  output logic        bbox_valid,
  output logic        shape_found,
  output logic [12:0] min_x,
  output logic [12:0] max_x,
  output logic [12:0] min_y,
  output logic [12:0] max_y,
  output logic [18:0] area,
  output logic [31:0] sum_x,
  output logic [31:0] sum_y,
  output logic [15:0] frame_count
);

  localparam logic [12:0] WIDTH_L    = 13'(WIDTH);
  localparam logic [12:0] HEIGHT_L   = 13'(HEIGHT);
  localparam logic [18:0] MIN_AREA_L = 19'(MIN_AREA);

  typedef enum logic [1:0] {IDLE, ARMED, SCAN} state_t;

  state_t      state;
  logic [12:0] x_cnt, y_cnt;
  logic        blank_q;
  logic [12:0] acc_min_x, acc_max_x, acc_min_y, acc_max_y;
  logic [18:0] acc_area;
  logic [31:0] acc_sum_x, acc_sum_y;
  logic        hit;
  logic        unused_hs;

  // Horizontal sync carries no information beyond what BLANK_N already gives.
  assign unused_hs = iVGA_HS;

  assign hit = (state == SCAN) && iVGA_BLANK_N && pix_dark &&
               (x_cnt < WIDTH_L) && (y_cnt < HEIGHT_L);

  always_ff @(posedge VGA_CLK) begin
    if (!reset_n) begin
      state       <= IDLE;
      x_cnt       <= '0;
      y_cnt       <= '0;
      blank_q     <= 1'b0;
      acc_min_x   <= '1;
      acc_max_x   <= '0;
      acc_min_y   <= '1;
      acc_max_y   <= '0;
      acc_area    <= '0;
      acc_sum_x   <= '0;
      acc_sum_y   <= '0;
      bbox_valid  <= 1'b0;
      shape_found <= 1'b0;
      min_x       <= '0;
      max_x       <= '0;
      min_y       <= '0;
      max_y       <= '0;
      area        <= '0;
      sum_x       <= '0;
      sum_y       <= '0;
      frame_count <= '0;
    end else begin
      bbox_valid <= 1'b0;
      blank_q    <= iVGA_BLANK_N;

      if (!iVGA_BLANK_N)
        x_cnt <= '0;
      else if (x_cnt != '1)
        x_cnt <= x_cnt + 13'd1;

      if (blank_q && !iVGA_BLANK_N && (y_cnt != '1))
        y_cnt <= y_cnt + 13'd1;

      case (state)
        IDLE: begin
          if (!iVGA_VS) state <= ARMED;
        end

        ARMED: begin
          y_cnt     <= '0;
          acc_min_x <= '1;
          acc_max_x <= '0;
          acc_min_y <= '1;
          acc_max_y <= '0;
          acc_area  <= '0;
          acc_sum_x <= '0;
          acc_sum_y <= '0;
          if (iVGA_VS) state <= SCAN;
        end

        SCAN: begin
          if (!iVGA_VS) begin
            state <= ARMED;
            if (!freeze) begin
              bbox_valid  <= 1'b1;
              frame_count <= frame_count + 16'd1;
              shape_found <= (acc_area >= MIN_AREA_L);
              area        <= acc_area;
              // An empty frame reports zeros rather than the all-ones min seeds.
              if (acc_area == '0) begin
                min_x <= '0;
                max_x <= '0;
                min_y <= '0;
                max_y <= '0;
                sum_x <= '0;
                sum_y <= '0;
              end else begin
                min_x <= acc_min_x;
                max_x <= acc_max_x;
                min_y <= acc_min_y;
                max_y <= acc_max_y;
                sum_x <= acc_sum_x;
                sum_y <= acc_sum_y;
              end
            end
          end else if (hit) begin
            if (acc_area != '1) acc_area <= acc_area + 19'd1;
            acc_sum_x <= acc_sum_x + {19'd0, x_cnt};
            acc_sum_y <= acc_sum_y + {19'd0, y_cnt};
            if (x_cnt < acc_min_x) acc_min_x <= x_cnt;
            if (x_cnt > acc_max_x) acc_max_x <= x_cnt;
            if (y_cnt < acc_min_y) acc_min_y <= y_cnt;
            if (y_cnt > acc_max_y) acc_max_y <= y_cnt;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
